// File: rtl/bit_deserializer_if.sv
// Serial-in / word-out bundle for bit_deserializer.
// Optional word_parity exists only when DESER_PARITY_EN is defined.
interface bit_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             bit_in;
    logic             bit_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overflow;
    logic             ovf_clr;
`ifdef DESER_PARITY_EN
    logic             word_parity;
`endif

    modport slave (
        input  bit_in, bit_en, word_ready, ovf_clr,
`ifdef DESER_PARITY_EN
        output word_parity,
`endif
        output word_out, word_valid, bit_cnt, overflow
    );

    modport master (
        output bit_in, bit_en, word_ready, ovf_clr,
`ifdef DESER_PARITY_EN
        input  word_parity,
`endif
        input  word_out, word_valid, bit_cnt, overflow
    );
endinterface

// File: rtl/bit_deserializer.sv
// Packs WIDTH enabled serial samples into a word behind a one-word holding register.
// Define DESER_PARITY_EN to add a registered even-parity output word_parity.
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bit_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             w_compl;
    logic             w_load;
    logic             w_ovf_set;

    always_comb begin
        if (MSB_FIRST)
            w_shift_nxt = {r_shift[WIDTH-2:0], bus.bit_in};
        else
            w_shift_nxt = {bus.bit_in, r_shift[WIDTH-1:1]};
    end

    assign w_compl = bus.bit_en && (r_cnt == CW'(WIDTH - 1));

    // A completion finding the holder full and unread is the only drop case
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_compl) begin
                    w_state_nxt = FULL;
                    w_load      = 1'b1;
                end
            end
            FULL: begin
                if (bus.word_ready) begin
                    if (w_compl)
                        w_load = 1'b1;
                    else
                        w_state_nxt = EMPTY;
                end else if (w_compl) begin
                    w_ovf_set = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.bit_en) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= w_compl ? '0 : r_cnt + CW'(1);
            end
            if (w_load)
                r_word <= w_shift_nxt;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (bus.ovf_clr)
                r_ovf <= 1'b0;
        end
    end

`ifdef DESER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity <= 1'b0;
        else if (w_load)
            r_parity <= ^w_shift_nxt;
    end

    assign bus.word_parity = r_parity;
`endif

    assign bus.word_out   = r_word;
    assign bus.word_valid = (r_state == FULL);
    assign bus.bit_cnt    = r_cnt;
    assign bus.overflow   = r_ovf;

endmodule
